// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 4-stage core datapath and pipe_hazard_ctrl.
// The datapath side uses 'master'; the control unit uses 'slave'.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [3:0]       id_rs;
    logic [3:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [3:0]       ex_rd;
    logic             ex_readmem;
    logic             ex_regwrite;
    logic             branch_taken;
    logic             halt_req;
    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output start, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd,
               ex_readmem, ex_regwrite, branch_taken, halt_req,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, halted,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  start, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd,
               ex_readmem, ex_regwrite, branch_taken, halt_req,
        output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, halted,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 4-stage core: load-use stalls, post-branch flush
// window, halt, and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       down_q, down_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic stall_inc;
    logic flush_inc;
    logic pc_write_en;
    logic ifid_write_en;
    logic ifid_flush;
    logic idex_bubble;
    logic halted;

    always_comb begin
        load_use = hz.ex_readmem & hz.ex_regwrite &
                   ((hz.id_uses_rs & (hz.id_rs == hz.ex_rd)) |
                    (hz.id_uses_rt & (hz.id_rt == hz.ex_rd)));
    end

    always_comb begin
        state_d       = state_q;
        down_d        = down_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b1;
        halted        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ifid_flush = 1'b1;
                if (hz.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (hz.branch_taken) begin
                    // Wrong-path instruction in IF/ID is replaced by a NOP,
                    // so the register must capture while flushing.
                    pc_write_en   = 1'b1;
                    ifid_write_en = 1'b1;
                    ifid_flush    = 1'b1;
                    flush_inc     = 1'b1;
                    down_d        = FLUSH_LOAD;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = S_FLUSH;
                    end
                end else if (load_use) begin
                    stall_inc = 1'b1;
                end else if (hz.halt_req) begin
                    state_d = S_HALT;
                end else begin
                    pc_write_en   = 1'b1;
                    ifid_write_en = 1'b1;
                    idex_bubble   = 1'b0;
                end
            end
            S_FLUSH: begin
                pc_write_en   = 1'b1;
                ifid_write_en = 1'b1;
                ifid_flush    = 1'b1;
                flush_inc     = 1'b1;
                down_d        = down_q - 4'd1;
                if (down_q <= 4'd1) begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Counters stick at all-ones so a long run never reads back as small.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            down_q      <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            down_q      <= down_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.pc_write_en   = pc_write_en;
    assign hz.ifid_write_en = ifid_write_en;
    assign hz.ifid_flush    = ifid_flush;
    assign hz.idex_bubble   = idex_bubble;
    assign hz.halted        = halted;
    assign hz.stall_cnt     = stall_cnt_q;
    assign hz.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl; two instances run in lockstep
// on identical inputs, one with a 2-cycle and one with a 1-cycle flush window.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 8;
    localparam int SAT   = 255;

    typedef struct packed {
        logic       start;
        logic [3:0] id_rs;
        logic [3:0] id_rt;
        logic       id_uses_rs;
        logic       id_uses_rt;
        logic [3:0] ex_rd;
        logic       ex_readmem;
        logic       ex_regwrite;
        logic       branch_taken;
        logic       halt_req;
    } in_t;

    // ctl = {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, halted}
    typedef struct {
        logic [4:0] ctl;
        int         scnt;
        int         fcnt;
    } exp_t;

    localparam logic [4:0] CTL_IDLE  = 5'b00110;
    localparam logic [4:0] CTL_HALT  = 5'b00011;
    localparam logic [4:0] CTL_FLUSH = 5'b11110;
    localparam logic [4:0] CTL_STALL = 5'b00010;
    localparam logic [4:0] CTL_RUN   = 5'b11000;

    logic clk;
    logic rst_n;
    in_t  cur_in;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) if0 ();
    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) if1 ();

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut0 (.clk(clk), .rst_n(rst_n), .hz(if0));
    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(CNT_W)) dut1 (.clk(clk), .rst_n(rst_n), .hz(if1));

    assign if0.start        = cur_in.start;
    assign if0.id_rs        = cur_in.id_rs;
    assign if0.id_rt        = cur_in.id_rt;
    assign if0.id_uses_rs   = cur_in.id_uses_rs;
    assign if0.id_uses_rt   = cur_in.id_uses_rt;
    assign if0.ex_rd        = cur_in.ex_rd;
    assign if0.ex_readmem   = cur_in.ex_readmem;
    assign if0.ex_regwrite  = cur_in.ex_regwrite;
    assign if0.branch_taken = cur_in.branch_taken;
    assign if0.halt_req     = cur_in.halt_req;
    assign if1.start        = cur_in.start;
    assign if1.id_rs        = cur_in.id_rs;
    assign if1.id_rt        = cur_in.id_rt;
    assign if1.id_uses_rs   = cur_in.id_uses_rs;
    assign if1.id_uses_rt   = cur_in.id_uses_rt;
    assign if1.ex_rd        = cur_in.ex_rd;
    assign if1.ex_readmem   = cur_in.ex_readmem;
    assign if1.ex_regwrite  = cur_in.ex_regwrite;
    assign if1.branch_taken = cur_in.branch_taken;
    assign if1.halt_req     = cur_in.halt_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle_no = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: mode flags plus a count of flush cycles still owed.
    int m_fc[2]     = '{2, 1};
    bit m_idle[2]   = '{1'b1, 1'b1};
    bit m_halt[2]   = '{1'b0, 1'b0};
    int m_left[2]   = '{0, 0};
    int m_scnt[2]   = '{0, 0};
    int m_fcnt[2]   = '{0, 0};

    function automatic int sat_inc(int v);
        return (v < SAT) ? v + 1 : SAT;
    endfunction

    function automatic exp_t model_step(int k, bit rst_low, in_t in);
        exp_t e;
        bit   hazard;
        hazard = in.ex_readmem && in.ex_regwrite &&
                 ((in.id_uses_rs && in.id_rs == in.ex_rd) ||
                  (in.id_uses_rt && in.id_rt == in.ex_rd));
        if (rst_low) begin
            m_idle[k] = 1'b1;
            m_halt[k] = 1'b0;
            m_left[k] = 0;
            m_scnt[k] = 0;
            m_fcnt[k] = 0;
        end
        e.scnt = m_scnt[k];
        e.fcnt = m_fcnt[k];
        if (rst_low) begin
            e.ctl = CTL_IDLE;
        end else if (m_idle[k]) begin
            e.ctl = CTL_IDLE;
            if (in.start) m_idle[k] = 1'b0;
        end else if (m_halt[k]) begin
            e.ctl = CTL_HALT;
        end else if (m_left[k] > 0) begin
            e.ctl = CTL_FLUSH;
            m_fcnt[k] = sat_inc(m_fcnt[k]);
            m_left[k] = m_left[k] - 1;
        end else if (in.branch_taken) begin
            e.ctl = CTL_FLUSH;
            m_fcnt[k] = sat_inc(m_fcnt[k]);
            m_left[k] = m_fc[k] - 1;
        end else if (hazard) begin
            e.ctl = CTL_STALL;
            m_scnt[k] = sat_inc(m_scnt[k]);
        end else if (in.halt_req) begin
            e.ctl = CTL_STALL;
            m_halt[k] = 1'b1;
        end else begin
            e.ctl = CTL_RUN;
        end
        return e;
    endfunction

    // rst_op: 0 none, 1 assert mid-cycle, 2 release, 3 keep asserted
    task automatic cyc(input in_t in, input int rst_op);
        bit low;
        @(posedge clk);
        #1;
        cycle_no++;
        cur_in = in;
        if (rst_op == 2) rst_n = 1'b1;
        if (rst_op == 1) begin
            #1;
            rst_n = 1'b0;
        end
        low = (rst_n == 1'b0);
        q0.push_back(model_step(0, low, in));
        q1.push_back(model_step(1, low, in));
    endtask

    function automatic in_t nop_in();
        in_t n;
        n = '0;
        return n;
    endfunction

    function automatic in_t rnd_in(int pbr, int phalt);
        in_t n;
        n.start        = 1'($urandom_range(0, 1));
        n.id_rs        = 4'($urandom_range(0, 3));
        n.id_rt        = 4'($urandom_range(0, 3));
        n.id_uses_rs   = 1'($urandom_range(0, 1));
        n.id_uses_rt   = 1'($urandom_range(0, 1));
        n.ex_rd        = 4'($urandom_range(0, 3));
        n.ex_readmem   = ($urandom_range(0, 99) < 35);
        n.ex_regwrite  = ($urandom_range(0, 99) < 75);
        n.branch_taken = ($urandom_range(0, 99) < pbr);
        n.halt_req     = ($urandom_range(0, 999) < phalt);
        return n;
    endfunction

    function automatic in_t load_use_in(bit uses);
        in_t n;
        n = '0;
        n.ex_readmem  = 1'b1;
        n.ex_regwrite = 1'b1;
        n.ex_rd       = 4'd3;
        n.id_rs       = 4'd3;
        n.id_uses_rs  = uses;
        return n;
    endfunction

    task automatic check(input string name, input int dut, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle=%0d got=%0h expected=%0h", name, dut, cycle_no, got, exp);
        end
    endtask

    // Monitor: outputs are combinational, so compare every cycle at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0 && q1.size() > 0) begin
                e = q0.pop_front();
                check("ctl", 0, int'({if0.pc_write_en, if0.ifid_write_en, if0.ifid_flush,
                                      if0.idex_bubble, if0.halted}), int'(e.ctl));
                check("stall_cnt", 0, int'(if0.stall_cnt), e.scnt);
                check("flush_cnt", 0, int'(if0.flush_cnt), e.fcnt);
                e = q1.pop_front();
                check("ctl", 1, int'({if1.pc_write_en, if1.ifid_write_en, if1.ifid_flush,
                                      if1.idex_bubble, if1.halted}), int'(e.ctl));
                check("stall_cnt", 1, int'(if1.stall_cnt), e.scnt);
                check("flush_cnt", 1, int'(if1.flush_cnt), e.fcnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cycle_no);
        $fatal(1, "watchdog expired");
    end

    task automatic restart();
        in_t s;
        s = nop_in();
        cyc(s, 3);
        cyc(s, 2);
        s.start = 1'b1;
        cyc(s, 0);
    endtask

    initial begin
        in_t s;
        int  drain;
        rst_n  = 1'b0;
        cur_in = '0;

        repeat (3) cyc(nop_in(), 3);
        cyc(nop_in(), 2);
        s = nop_in();
        s.start = 1'b1;
        cyc(s, 0);
        repeat (2) cyc(nop_in(), 0);

        // Single load-use, then the same shape with rs unused.
        cyc(load_use_in(1'b1), 0);
        cyc(nop_in(), 0);
        cyc(load_use_in(1'b0), 0);
        cyc(nop_in(), 0);

        s = nop_in();
        s.branch_taken = 1'b1;
        cyc(s, 0);
        repeat (3) cyc(nop_in(), 0);

        s = load_use_in(1'b1);
        s.branch_taken = 1'b1;
        cyc(s, 0);
        repeat (3) cyc(nop_in(), 0);

        repeat (300) cyc(rnd_in(10, 0), 0);

        // Halt, then random traffic that must not disturb it.
        s = nop_in();
        s.halt_req = 1'b1;
        cyc(s, 0);
        repeat (8) cyc(rnd_in(30, 0), 0);
        cyc(rnd_in(0, 0), 1);
        restart();

        repeat (300) cyc(load_use_in(1'b1), 0);
        cyc(nop_in(), 0);

        // Reset while dut0 is inside its flush window.
        s = nop_in();
        s.branch_taken = 1'b1;
        cyc(s, 0);
        cyc(nop_in(), 1);
        restart();

        for (int seg = 0; seg < 3; seg++) begin
            repeat (200) cyc(rnd_in(8, 10), 0);
            cyc(rnd_in(8, 0), 1);
            restart();
        end
        repeat (20) cyc(rnd_in(8, 0), 0);

        drain = 0;
        while ((q0.size() > 0 || q1.size() > 0) && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        @(posedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d expected=0", q0.size() + q1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
